// File: rtl/bcd4_to_binary.sv
// -----------------------------------------------------------------------------
// bcd4_to_binary
//   Sequential packed-BCD to unsigned binary converter. One BCD digit is
//   folded into the accumulator per clock (acc = acc*10 + d), most significant
//   digit first. A conversion takes DIGITS cycles in CONV followed by one FIN
//   cycle; the registered DONE pulse and result appear on the edge leaving FIN.
//   A digit greater than 9 anywhere in the operand flags ERR and forces BIN=0.
//
// Parameters
//   DIGITS  number of packed BCD digits (1..6)
//   BW      result width, ceil(log2(10^DIGITS)) (derived, do not override)
//
// Ports
//   CLK    in   clock, all state changes on the rising edge
//   CLR    in   synchronous active-high clear, beats START and every transition
//   START  in   conversion request, honoured only in IDLE
//   BCD    in   packed BCD operand, MS digit in BCD[4*DIGITS-1 -: 4]
//   BIN    out  binary result, held until the next completion or CLR
//   BUSY   out  high during the DIGITS CONV cycles
//   DONE   out  one-cycle completion pulse, coincident with BIN/ERR update
//   ERR    out  last completed conversion contained an illegal digit
// -----------------------------------------------------------------------------
module bcd4_to_binary #(
  parameter  int DIGITS = 4,
  // ceil(log2(10^DIGITS)) for the legal DIGITS range
  localparam int BW = (DIGITS == 1) ? 4  :
                      (DIGITS == 2) ? 7  :
                      (DIGITS == 3) ? 10 :
                      (DIGITS == 4) ? 14 :
                      (DIGITS == 5) ? 17 : 20
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic [BW-1:0]         BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] sr_q,    sr_d;
  logic [BW-1:0]       acc_q,   acc_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic                err_q,   err_d;     // error seen in current conversion
  logic [BW-1:0]       bin_q,   bin_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                errout_q, errout_d; // error of last completed conversion

  logic [3:0]    digit;
  logic          digit_bad;
  logic [BW-1:0] acc_x10_plus_d;

  assign digit     = sr_q[4*DIGITS-1 -: 4];
  // 1010..1111 are the only non-decimal codes
  assign digit_bad = digit[3] & (digit[2] | digit[1]);

  // acc*10 + d as (acc<<3) + (acc<<1) + d; an all-9s operand fits in BW bits,
  // and an illegal digit may wrap but its result is discarded anyway.
  assign acc_x10_plus_d = {acc_q[BW-4:0], 3'b000}
                        + {acc_q[BW-2:0], 1'b0}
                        + BW'(digit);

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    bin_d    = bin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    errout_d = errout_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          sr_d    = BCD;
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = CW'(DIGITS);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end

      CONV: begin
        acc_d = acc_x10_plus_d;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q - 1'b1;
        if (digit_bad) begin
          err_d = 1'b1;
        end
        // last digit processed on this edge
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end

      FIN: begin
        done_d   = 1'b1;
        bin_d    = err_q ? '0 : acc_q;
        errout_d = err_q;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      bin_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      errout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      errout_q <= errout_d;
    end
  end

  assign BIN  = bin_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = errout_q;

endmodule

// File: doc/bcd4_to_binary.md
BCD4_TO_BINARY -- requirements
Module: bcd4_to_binary

Interface
REQ-001 Parameter DIGITS, default 4: number of packed BCD digits converted; legal range 1..6.
REQ-002 Derived constant BW = ceil(log2(10^DIGITS)); BW = 14 at DIGITS = 4.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 CLR  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  conversion request; sampled only in IDLE.
REQ-006 BCD  input  4*DIGITS  packed BCD operand; BCD[4*DIGITS-1 -: 4] is the most significant digit.
REQ-007 BIN  output  BW  unsigned binary result; registered.
REQ-008 BUSY  output  1  high while a conversion is in progress; registered.
REQ-009 DONE  output  1  one-cycle pulse when BIN and ERR update; registered.
REQ-010 ERR  output  1  high when the last completed conversion saw a digit > 9; registered.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CONV, FIN.
REQ-012 In IDLE with START=1, the block SHALL capture BCD into an internal shift register, clear the accumulator, clear the internal error flag, load the digit counter with DIGITS, go to CONV, and set BUSY=1.
REQ-013 BCD SHALL be sampled only at the accepting edge; later changes to BCD SHALL NOT affect the result.
REQ-014 Each CONV cycle SHALL process the top digit d: acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d, at BW-bit width without overflow.
REQ-015 Each CONV cycle SHALL shift the shift register left by 4 bits and decrement the digit counter.
REQ-016 Any processed digit with d > 9 SHALL set the internal error flag for the rest of that conversion, and all DIGITS cycles SHALL still run.
REQ-017 After the DIGITS-th CONV cycle the FSM SHALL enter FIN.
REQ-018 In FIN the outputs SHALL be: DONE=1, BUSY=0; BIN=acc and ERR=0 if no error; BIN=0 and ERR=1 if error.
REQ-019 FIN SHALL last exactly one cycle and then return to IDLE.
REQ-020 Latency: DONE SHALL be high in the cycle following the (DIGITS+1)-th posedge after the edge that accepted START, i.e. after 5 edges at DIGITS=4.
REQ-021 BIN and ERR SHALL hold their values until the next FIN or CLR.
REQ-022 START in CONV or FIN SHALL be ignored, not queued; a START held high SHALL begin a new conversion from the first IDLE cycle.
REQ-023 DONE SHALL never be high for two consecutive cycles.

Reset
REQ-024 CLR=1 at a posedge SHALL force state=IDLE, BIN=0, BUSY=0, DONE=0, ERR=0, and clear the accumulator, counter and shift register.
REQ-025 CLR SHALL have priority over START and over every FSM transition, including mid-conversion.
REQ-026 An aborted conversion SHALL produce no DONE pulse.
REQ-027 The first START after CLR deasserts SHALL convert normally.

Verification
REQ-028 CLR, then BCD=16'h1234 with START for 1 cycle -> after 5 edges DONE=1 for one cycle, BIN=1234 (14'h04D2), ERR=0; BUSY high in the 4 CONV cycles.
REQ-029 BCD=16'h9999 -> BIN=9999 (14'h270F), ERR=0. BCD=16'h0000 -> BIN=0, ERR=0.
REQ-030 BCD=16'h12A4 -> DONE after 5 edges with ERR=1 and BIN=0. A following BCD=16'h0042 -> BIN=42, ERR=0.
REQ-031 START held high for 10 cycles, with BCD changed to 16'h5555 one cycle after acceptance of 16'h0007 -> first DONE reports BIN=7; the second conversion starts in the IDLE cycle after FIN and reports 5555; exactly one DONE pulse per conversion.
REQ-032 CLR asserted during the 2nd CONV cycle of 16'h8888 -> next edge BUSY=0, BIN=0, ERR=0, no DONE. A new START with 16'h0100 then gives BIN=100.
REQ-033 CLR and START high on the same edge in IDLE -> no conversion starts and BUSY stays 0.
